// File: rtl/lcd_pkg.sv
// Shared definitions for the ILI9486 8080-bus drivers: opcodes, MMIO register map,
// scheduler grant encoding and STATUS field positions.
package lcd_pkg;

    // ILI9486 command opcodes
    localparam logic [7:0] CmdNop           = 8'h00;
    localparam logic [7:0] CmdSwReset       = 8'h01;
    localparam logic [7:0] CmdSleepOut      = 8'h11;
    localparam logic [7:0] CmdDisplayOn     = 8'h29;
    localparam logic [7:0] CmdColAddrSet    = 8'h2A;
    localparam logic [7:0] CmdPageAddrSet   = 8'h2B;
    localparam logic [7:0] CmdMemWrite      = 8'h2C;
    localparam logic [7:0] CmdMemAccessCtrl = 8'h36;
    localparam logic [7:0] CmdScrollStart   = 8'h37;
    localparam logic [7:0] CmdPixelFormat   = 8'h3A;
    localparam logic [7:0] CmdGammaPos      = 8'hE0;
    localparam logic [7:0] CmdGammaNeg      = 8'hE1;

    // MMIO register offsets, selected by a[3:2]
    localparam logic [1:0] RegFifo   = 2'd0;
    localparam logic [1:0] RegCtrl   = 2'd1;
    localparam logic [1:0] RegStatus = 2'd2;
    localparam logic [1:0] RegRsvd   = 2'd3;

    // Scheduler state doubles as the grant value reported in STATUS
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCpu   = 2'd1,
        StFcmd  = 2'd2,
        StFdata = 2'd3
    } grant_e;

    localparam int unsigned StatusFrameLsb = 24;
    localparam int unsigned StatusOvfBit   = 16;
    localparam int unsigned StatusBusyBit  = 15;
    localparam int unsigned StatusGrantLsb = 13;

endpackage

// File: rtl/lcd_wr_strobe.sv
// One 8080-style write cycle: wr low for WR_LOW cycles then high for WR_HIGH, with data and
// rs held for the whole period. A new start may be issued in the done cycle for zero-gap bursts.
module lcd_wr_strobe #(
    parameter int unsigned WR_LOW  = 2,
    parameter int unsigned WR_HIGH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       rs_in,
    output logic [7:0] lcd_d,
    output logic       rs,
    output logic       wr,
    output logic       busy,
    output logic       done
);
    localparam int unsigned Period = WR_LOW + WR_HIGH;
    localparam int unsigned CntW   = $clog2(Period);
    localparam logic [CntW-1:0] CntLast = CntW'(Period - 1);
    localparam logic [CntW-1:0] CntLow  = CntW'(WR_LOW);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            active_q, active_d;
    logic [7:0]      data_q, data_d;
    logic            rs_q, rs_d;
    logic            wr_q, wr_d;

    always_comb begin
        done     = active_q && (cnt_q == CntLast);
        cnt_d    = cnt_q;
        active_d = active_q;
        data_d   = data_q;
        rs_d     = rs_q;
        if (start) begin
            cnt_d    = '0;
            active_d = 1'b1;
            data_d   = data_in;
            rs_d     = rs_in;
        end else if (done) begin
            active_d = 1'b0;
        end else if (active_q) begin
            cnt_d = cnt_q + 1'b1;
        end
        // wr is registered so the pin never glitches between bytes
        wr_d = !(active_d && (cnt_d < CntLow));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            data_q   <= 8'h00;
            rs_q     <= 1'b1;
            wr_q     <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            data_q   <= data_d;
            rs_q     <= rs_d;
            wr_q     <= wr_d;
        end
    end

    assign lcd_d = data_q;
    assign rs    = rs_q;
    assign wr    = wr_q;
    assign busy  = active_q;

endmodule

// File: rtl/lcd_bus_sched.sv
// Arbitrates the LCD write bus between the CPU command FIFO and the frame streamer; CPU
// traffic only gets the bus between frames, and each frame is prefixed with MEM_WRITE.
module lcd_bus_sched
    import lcd_pkg::*;
#(
    parameter int unsigned FIFO_AW = 4,
    parameter int unsigned WR_LOW  = 2,
    parameter int unsigned WR_HIGH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic        we,
    output logic [31:0] spo,
    input  logic        st_valid,
    input  logic [7:0]  st_byte,
    input  logic        st_last,
    output logic        st_ready,
    output logic [7:0]  lcd_d,
    output logic        wr,
    output logic        rs,
    output logic        rd,
    output logic        cs
);
    localparam int unsigned Depth = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] LevelFull = (FIFO_AW + 1)'(Depth);

    logic [1:0]         reg_sel;
    logic [8:0]         fifo_mem [Depth];
    logic [FIFO_AW-1:0] wptr_q, rptr_q;
    logic [FIFO_AW:0]   level_q;
    logic [8:0]         head;
    logic               push_req, push, pop, full, ovf_set, ovf_clr;
    logic               ref_en_q, ovf_q;
    logic [7:0]         frame_cnt_q;
    grant_e             state_q, state_d;
    logic               last_q, last_d;
    logic               frame_inc, busy;
    logic               tx_start, tx_rs, wr_busy, wr_done;
    logic [7:0]         tx_data;
    logic               unused_bits;

    assign reg_sel  = a[3:2];
    assign push_req = we && (reg_sel == RegFifo);
    assign full     = (level_q == LevelFull);
    // A pop in the same cycle frees a slot, so a push at full is still accepted
    assign push     = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign ovf_clr  = we && (reg_sel == RegStatus) && d[StatusOvfBit];
    assign head     = fifo_mem[rptr_q];
    assign busy     = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr_q] <= d[8:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_en_q    <= 1'b0;
            ovf_q       <= 1'b0;
            frame_cnt_q <= 8'h00;
            state_q     <= StIdle;
            last_q      <= 1'b0;
        end else begin
            if (we && (reg_sel == RegCtrl)) ref_en_q <= d[0];
            if (ovf_set)      ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
            if (frame_inc) frame_cnt_q <= frame_cnt_q + 8'd1;
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        tx_start  = 1'b0;
        tx_data   = 8'h00;
        tx_rs     = 1'b1;
        pop       = 1'b0;
        st_ready  = 1'b0;
        frame_inc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (level_q != '0) begin
                    state_d  = StCpu;
                    pop      = 1'b1;
                    tx_start = 1'b1;
                    tx_data  = head[7:0];
                    tx_rs    = head[8];
                end else if (ref_en_q && st_valid) begin
                    state_d  = StFcmd;
                    tx_start = 1'b1;
                    tx_data  = CmdMemWrite;
                    tx_rs    = 1'b0;
                end
            end
            StCpu: begin
                if (wr_done) begin
                    if (level_q != '0) begin
                        pop      = 1'b1;
                        tx_start = 1'b1;
                        tx_data  = head[7:0];
                        tx_rs    = head[8];
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StFcmd: begin
                if (wr_done) begin
                    state_d = StFdata;
                    if (st_valid) begin
                        st_ready = 1'b1;
                        tx_start = 1'b1;
                        tx_data  = st_byte;
                        last_d   = st_last;
                    end
                end
            end
            StFdata: begin
                // last_q: final byte already accepted, only its completion is awaited
                if (last_q) begin
                    if (wr_done) begin
                        state_d   = StIdle;
                        last_d    = 1'b0;
                        frame_inc = 1'b1;
                    end
                end else if ((!wr_busy || wr_done) && st_valid) begin
                    st_ready = 1'b1;
                    tx_start = 1'b1;
                    tx_data  = st_byte;
                    last_d   = st_last;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    lcd_wr_strobe #(
        .WR_LOW  (WR_LOW),
        .WR_HIGH (WR_HIGH)
    ) u_strobe (
        .clk     (clk),
        .rst     (rst),
        .start   (tx_start),
        .data_in (tx_data),
        .rs_in   (tx_rs),
        .lcd_d   (lcd_d),
        .rs      (rs),
        .wr      (wr),
        .busy    (wr_busy),
        .done    (wr_done)
    );

    always_comb begin
        spo = '0;
        case (reg_sel)
            RegCtrl: spo[0] = ref_en_q;
            RegStatus: begin
                spo[StatusFrameLsb +: 8] = frame_cnt_q;
                spo[StatusOvfBit]        = ovf_q;
                spo[StatusBusyBit]       = busy;
                spo[StatusGrantLsb +: 2] = state_q;
                spo[FIFO_AW:0]           = level_q;
            end
            default: spo = '0;
        endcase
    end

    assign cs = !busy;
    assign rd = 1'b1;

    assign unused_bits = ^{a[31:4], a[1:0], d[31:17], d[15:9]};

endmodule

// File: tb/tb_lcd_bus_sched.sv
// Randomised and directed bench for lcd_bus_sched; a transaction-level model predicts the
// byte stream on the LCD bus and a per-cycle monitor checks strobe timing against it.
module tb_lcd_bus_sched;
    localparam int unsigned FifoAw = 4;
    localparam int unsigned WrLow  = 2;
    localparam int unsigned WrHigh = 2;
    localparam int unsigned Depth  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] d = '0;
    logic        we = 1'b0;
    logic [31:0] spo;
    logic        st_valid = 1'b0;
    logic [7:0]  st_byte = 8'h00;
    logic        st_last = 1'b0;
    logic        st_ready;
    logic [7:0]  lcd_d;
    logic        wr, rs, rd, cs;

    lcd_bus_sched #(
        .FIFO_AW (FifoAw),
        .WR_LOW  (WrLow),
        .WR_HIGH (WrHigh)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .d        (d),
        .we       (we),
        .spo      (spo),
        .st_valid (st_valid),
        .st_byte  (st_byte),
        .st_last  (st_last),
        .st_ready (st_ready),
        .lcd_d    (lcd_d),
        .wr       (wr),
        .rs       (rs),
        .rd       (rd),
        .cs       (cs)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state: pending CPU entries (with push cycle), streamer feed, expected frame bytes
    logic [8:0] cpu_q[$];
    int         cpu_t[$];
    logic [8:0] stream_q[$];
    logic [8:0] frame_exp[$];
    logic [8:0] bus_log[$];
    int         fall_cyc[$];
    bit         in_frame = 1'b0;
    int         frames_done = 0;
    bit         stall = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic see_byte(input logic [8:0] v);
        logic [8:0] e;
        int old;
        bus_log.push_back(v);
        fall_cyc.push_back(cyc);
        if (in_frame) begin
            if (frame_exp.size() == 0) begin
                flag("frame_extra_byte");
            end else begin
                e = frame_exp.pop_front();
                check("frame_byte", {23'b0, v}, {23'b0, 1'b1, e[7:0]});
                if (e[8]) begin
                    in_frame = 1'b0;
                    frames_done++;
                end
            end
        end else if (v == 9'h02C) begin
            old = 0;
            foreach (cpu_t[i]) if (cpu_t[i] + 3 <= cyc) old++;
            check("cpu_before_frame", old, 0);
            if (frame_exp.size() == 0) flag("unexpected_frame");
            else in_frame = 1'b1;
        end else begin
            if (cpu_q.size() == 0) begin
                flag("cpu_extra_byte");
            end else begin
                e = cpu_q.pop_front();
                void'(cpu_t.pop_front());
                check("cpu_byte", {23'b0, v}, {23'b0, e});
            end
        end
    endtask

    // Bus monitor: strobe shape, hold times, and hands each byte to the model
    initial begin : monitor
        logic       wr_prev;
        int         low_cnt, high_cnt;
        bit         seen;
        logic [8:0] cur;
        wr_prev = 1'b1; low_cnt = 0; high_cnt = 0; seen = 1'b0; cur = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                wr_prev = 1'b1; seen = 1'b0; low_cnt = 0; high_cnt = 0;
            end else begin
                check("rd_const", rd, 1);
                if (st_ready) check("st_ready_needs_valid", st_valid, 1);
                if (!wr) begin
                    check("cs_low_in_strobe", cs, 0);
                    if (wr_prev) begin
                        if (seen) check("wr_high_min", high_cnt >= WrHigh, 1);
                        cur = {rs, lcd_d};
                        seen = 1'b1;
                        low_cnt = 1;
                        see_byte(cur);
                    end else begin
                        check("hold_low", {23'b0, rs, lcd_d}, {23'b0, cur});
                        low_cnt++;
                    end
                    high_cnt = 0;
                end else begin
                    if (!wr_prev) check("wr_low_len", low_cnt, WrLow);
                    if (seen && high_cnt < WrHigh) check("hold_high", {23'b0, rs, lcd_d}, {23'b0, cur});
                    high_cnt++;
                    low_cnt = 0;
                end
                wr_prev = wr;
            end
        end
    end

    // Streamer: offers the head of stream_q, pops it on handshake
    initial begin : streamer
        bit took;
        forever begin
            @(negedge clk);
            took = rst && st_valid && st_ready;
            @(posedge clk);
            #1;
            if (took && stream_q.size() > 0) void'(stream_q.pop_front());
            st_valid = (stream_q.size() > 0) && !stall;
            st_byte  = (stream_q.size() > 0) ? stream_q[0][7:0] : 8'h00;
            st_last  = (stream_q.size() > 0) ? stream_q[0][8] : 1'b0;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "bench did not terminate");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mmio_wr(input logic [1:0] r, input logic [31:0] v);
        a = {28'b0, r, 2'b00};
        d = v;
        we = 1'b1;
        if (r == 2'd0 && cpu_q.size() < Depth) begin
            cpu_q.push_back(v[8:0]);
            cpu_t.push_back(cyc);
        end
        tick(1);
        we = 1'b0;
        a = '0;
    endtask

    task automatic read_reg(input logic [1:0] r, output logic [31:0] v);
        a = {28'b0, r, 2'b00};
        #1;
        v = spo;
        a = '0;
    endtask

    task automatic push_frame(input int len);
        logic [8:0] v;
        for (int i = 0; i < len; i++) begin
            v = {(i == len - 1), 8'($urandom_range(0, 255))};
            stream_q.push_back(v);
            frame_exp.push_back(v);
        end
    endtask

    task automatic wait_quiet(input string name, input int budget);
        logic [31:0] s;
        int n;
        n = 0;
        forever begin
            read_reg(2'd2, s);
            if (stream_q.size() == 0 && cpu_q.size() == 0 && frame_exp.size() == 0 &&
                !in_frame && !s[15]) break;
            if (n >= budget) begin
                flag({name, "_timeout"});
                break;
            end
            tick(1);
            n++;
        end
    endtask

    task automatic wait_log(input string name, input int n, input int budget);
        int k;
        k = 0;
        while (bus_log.size() < n) begin
            if (k >= budget) begin
                flag({name, "_timeout"});
                break;
            end
            tick(1);
            k++;
        end
    endtask

    function automatic logic [8:0] rand_cpu();
        logic [8:0] e;
        e = 9'($urandom_range(0, 511));
        if (e == 9'h02C) e = 9'h02B;
        return e;
    endfunction

    logic [8:0] exp_cpu [5];
    logic [31:0] s;
    int base;

    initial begin : main
        exp_cpu[0] = 9'h02A; exp_cpu[1] = 9'h100; exp_cpu[2] = 9'h100;
        exp_cpu[3] = 9'h101; exp_cpu[4] = 9'h1DF;

        // Reset values and idle
        #12;
        check("rst_lcd_d", lcd_d, 0);
        check("rst_wr", wr, 1);
        check("rst_rs", rs, 1);
        check("rst_rd", rd, 1);
        check("rst_cs", cs, 1);
        check("rst_st_ready", st_ready, 0);
        tick(2);
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            read_reg(2'd2, s);
            check("idle_status", s, 0);
            check("idle_wr", wr, 1);
            check("idle_cs", cs, 1);
            tick(1);
        end

        // CPU command group
        base = bus_log.size();
        for (int i = 0; i < 5; i++) mmio_wr(2'd0, {23'b0, exp_cpu[i]});
        wait_quiet("cpu_group", 200);
        for (int i = 0; i < 5; i++) check("cpu_group_byte", {23'b0, bus_log[base + i]}, {23'b0, exp_cpu[i]});
        for (int i = 1; i < 5; i++) check("cpu_group_period", fall_cyc[base + i] - fall_cyc[base + i - 1], 4);
        read_reg(2'd2, s);
        check("cpu_group_level", s[4:0], 0);

        // Frame stream with a 10-cycle streamer stall
        mmio_wr(2'd1, 32'h1);
        base = bus_log.size();
        push_frame(6);
        begin : frame_copy
            logic [8:0] fr[$];
            fr = frame_exp;
            wait_log("frame_start", base + 3, 200);
            stall = 1'b1;
            tick(4);
            for (int i = 0; i < 6; i++) begin
                check("stall_wr_high", wr, 1);
                tick(1);
            end
            stall = 1'b0;
            wait_quiet("frame", 300);
            check("frame_cmd", {23'b0, bus_log[base]}, 32'h02C);
            for (int i = 0; i < 6; i++)
                check("frame_data", {23'b0, bus_log[base + 1 + i]}, {23'b0, 1'b1, fr[i][7:0]});
        end
        read_reg(2'd2, s);
        check("frame_cnt_1", s[31:24], 1);
        check("frame_grant_idle", s[14:13], 0);

        // CPU pushes mid-frame go out between frames
        base = bus_log.size();
        push_frame(6);
        push_frame(4);
        wait_log("arb", base + 4, 200);
        mmio_wr(2'd0, 32'h036);
        mmio_wr(2'd0, 32'h148);
        wait_quiet("arb", 400);
        check("arb_cpu0", {23'b0, bus_log[base + 7]}, 32'h036);
        check("arb_cpu1", {23'b0, bus_log[base + 8]}, 32'h148);
        check("arb_next_cmd", {23'b0, bus_log[base + 9]}, 32'h02C);
        read_reg(2'd2, s);
        check("frame_cnt_3", s[31:24], 3);

        // Overflow while a stalled frame holds the bus
        base = bus_log.size();
        push_frame(3);
        wait_log("ovf_frame", base + 2, 200);
        stall = 1'b1;
        mmio_wr(2'd1, 32'h0);
        for (int i = 0; i < 17; i++) mmio_wr(2'd0, {23'b0, rand_cpu()});
        read_reg(2'd2, s);
        check("ovf_level", s[4:0], 16);
        check("ovf_flag", s[16], 1);
        check("ovf_grant", s[14:13], 3);
        mmio_wr(2'd2, 32'h0001_0000);
        read_reg(2'd2, s);
        check("ovf_cleared", s[16], 0);
        check("ovf_level_kept", s[4:0], 16);
        stall = 1'b0;
        wait_quiet("ovf_drain", 400);
        read_reg(2'd2, s);
        check("frame_cnt_4", s[31:24], 4);

        // Randomised traffic
        mmio_wr(2'd1, 32'h1);
        for (int i = 0; i < 600; i++) begin
            stall = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 39) == 0 && frame_exp.size() < 20)
                push_frame(int'($urandom_range(1, 8)));
            if ($urandom_range(0, 7) == 0 && cpu_q.size() < 8) mmio_wr(2'd0, {23'b0, rand_cpu()});
            else tick(1);
        end
        stall = 1'b0;
        wait_quiet("random", 3000);
        read_reg(2'd2, s);
        check("random_frame_cnt", s[31:24], 32'(frames_done % 256));
        check("random_level", s[4:0], 0);
        check("random_ovf", s[16], 0);

        // Reset during wr low
        mmio_wr(2'd1, 32'h0);
        for (int i = 0; i < 3; i++) mmio_wr(2'd0, {23'b0, rand_cpu()});
        begin : wait_low
            int k;
            k = 0;
            while (wr !== 1'b0 && k < 50) begin
                tick(1);
                k++;
            end
            check("reset_saw_wr_low", wr, 0);
        end
        #2;
        rst = 1'b0;
        #1;
        check("reset_wr_async", wr, 1);
        check("reset_cs", cs, 1);
        check("reset_st_ready", st_ready, 0);
        cpu_q.delete();
        cpu_t.delete();
        in_frame = 1'b0;
        tick(3);
        rst = 1'b1;
        read_reg(2'd2, s);
        check("reset_level", s[4:0], 0);
        check("reset_status", s, 0);
        read_reg(2'd1, s);
        check("reset_ctrl", s, 0);
        tick(10);
        check("reset_wr_idle", wr, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lcd_bus_sched.md
# lcd_bus_sched

Scheduler for the shared 8-bit 8080-style write bus of the ILI9486 LCD panel. It arbitrates between two sources:
- a CPU command FIFO, loaded over the MMIO bus;
- a frame-refresh byte streamer fed from VRAM.

CPU traffic is granted only at frame boundaries. The block emits the MEM_WRITE (0x2C) command itself at the start of every frame. It sits between the system bus, the VRAM pixel streamer and the LCD pins, so software can reconfigure the panel (CAS/PAS, gamma, scroll) without corrupting a frame.

## Interface
Parameters:
- FIFO_AW, 4: CPU FIFO address width; depth is 2^FIFO_AW entries of 9 bits ({rs, byte}).
- WR_LOW, 2: cycles that wr is held low per byte (≥1).
- WR_HIGH, 2: cycles that wr is held high per byte (≥1).

Ports:
- clk  in  1  system clock; one clock, all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- a  in  32  MMIO address; a[3:2] selects the register.
- d  in  32  MMIO write data.
- we  in  1  MMIO write strobe, one cycle per write.
- spo  out  32  MMIO read data, combinational from a.
- st_valid  in  1  streamer has a pixel byte.
- st_byte  in  8  pixel byte.
- st_last  in  1  qualifies the final byte of a frame.
- st_ready  out  1  byte accepted this cycle (st_valid & st_ready).
- lcd_d  out  8  panel data bus.
- wr  out  1  write strobe, active low.
- rs  out  1  0 = command, 1 = data.
- rd  out  1  constant 1.
- cs  out  1  chip select, active low.

## Operation
Registers (a[3:2]):
- **0, FIFO:** a write pushes {d[8], d[7:0]}.
  - If the FIFO is full, the push is dropped and sticky `ovf` is set.
- **1, CTRL:** bit0 `ref_en` (reset 0).
- **2, STATUS:**
  - Read value: {frame_cnt[7:0] at [31:24], ovf at [16], busy at [15], grant[1:0] at [14:13], level[FIFO_AW:0] at [FIFO_AW:0]}.
  - Writing d[16]=1 clears `ovf`.
- **3:** reads as 0; writes are ignored.

Scheduler FSM (grant encoding 0/1/2/3):
- **IDLE (0):**
  - If level≠0 → CPU.
  - Else if ref_en & st_valid → FCMD.
- **CPU (1):** sends FIFO entries back to back. When the FIFO is empty at a byte completion → IDLE.
- **FCMD (2):** sends rs=0, 0x2C, then → FDATA.
- **FDATA (3):**
  - Each byte completion asserts st_ready if st_valid; the accepted byte is sent with rs=1.
  - When st_last is accepted: after that byte completes → IDLE, and frame_cnt increments (wraps 255→0).
  - Clearing ref_en mid-frame has no effect until the frame ends.

Byte strobe:
- A byte occupies WR_LOW+WR_HIGH cycles.
- lcd_d and rs are stable for the whole period.
- wr is low for the first WR_LOW cycles.
- cs is low while state≠IDLE.

## Timing
- Reset values:
  - lcd_d=0, wr=1, rs=1, rd=1, cs=1, st_ready=0.
  - FSM in IDLE; FIFO empty; ovf=0, ref_en=0, frame_cnt=0.
- Reset mid-byte: wr returns to 1 immediately (asynchronous); the FIFO is flushed.
- From IDLE with level≠0, the first wr falling edge occurs 1 cycle after the decision.
- Back-to-back bytes have a period of exactly WR_LOW+WR_HIGH with no gap, including FCMD→FDATA and successive CPU entries.
- st_ready is a single-cycle pulse, high only in the last cycle of the previous byte or in an idle FDATA cycle.
- If st_valid=0 in FDATA, wr stays high and the block waits; no timeout.
- A simultaneous push and pop leaves level unchanged; a push at full with a pop in the same cycle is accepted.
- A simultaneous ovf-clear and a new overflow: set wins.
- CPU pushes during FDATA wait until the frame ends.

## Structure
- Shared package `lcd_pkg`:
  - Command opcodes (0x2C MEM_WRITE and the other ILI9486 opcodes).
  - Register offsets.
  - Grant/state encodings.
  - STATUS bit positions.
- Sub-module `lcd_wr_strobe`: inputs start/byte/rs, outputs lcd_d/rs/wr/done. It is reused by later panel drivers.
- The FIFO is a local register array inside lcd_bus_sched.

## Test plan
- **Reset and idle:** release rst with no stimulus → wr=1, cs=1, STATUS reads 0 for 100 cycles.
- **CPU command group:** push 0x02A, 0x100, 0x100, 0x101, 0x1DF → 5 wr pulses, 4-cycle period; rs sequence 0,1,1,1,1; bytes 2A,00,00,01,DF; STATUS level returns to 0.
- **Frame stream:** set ref_en=1; the streamer supplies 6 bytes with st_last on the 6th → a 0x2C command followed by 6 data bytes; frame_cnt=1; the state returns to IDLE.
- **Frame-boundary arbitration:** push 2 CPU entries during the 3rd frame data byte → both are sent only after the frame's last byte, before the next 0x2C.
- **Overflow:** 17 pushes with ref_en=0 and the bus stalled by an in-progress frame → level=16, ovf=1; writing STATUS d[16]=1 clears ovf.
- **Streamer stall and reset mid-byte:**
  - Drop st_valid for 10 cycles in FDATA → wr stays high and no byte is lost.
  - Assert rst during wr low → wr=1 in the same cycle, and the FIFO level is 0 after release.
